// File: rtl/m_stage.sv
`default_nettype none
// ============================================================================
// Module   : m_stage
// Brief    : MIPS memory stage. Holds the E/M pipeline register, inserts a
//            bubble on an E stall, and contains a word-organised data memory
//            with byte/halfword/word stores and sign/zero-extending loads.
// Revision : 1.0 - initial release
// ============================================================================
module m_stage #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_E_I,
  input  logic [31:0] PC_E_I,
  input  logic [31:0] ALURS_E_I,
  input  logic [31:0] WD_E_I,
  input  logic        RFWr_E_I,
  input  logic [4:0]  DstE_E_I,
  input  logic        Stall_E_I,
  input  logic        ForwardRtM_M_I,
  input  logic [31:0] TWF_M_I,
  output logic [31:0] Instr_M_O,
  output logic [31:0] PC_M_O,
  output logic [31:0] ALURS_M_O,
  output logic [31:0] RD_M_O,
  output logic        RFWr_M_O,
  output logic [4:0]  DstM_M_O,
  output logic        AdEL_M_O,
  output logic        AdES_M_O
);

  localparam logic [31:0] c_DM_BYTES = 32'(DM_WORDS * 4);

  localparam logic [5:0] c_OP_SW  = 6'h2B;
  localparam logic [5:0] c_OP_SH  = 6'h29;
  localparam logic [5:0] c_OP_SB  = 6'h28;
  localparam logic [5:0] c_OP_LW  = 6'h23;
  localparam logic [5:0] c_OP_LH  = 6'h21;
  localparam logic [5:0] c_OP_LHU = 6'h25;
  localparam logic [5:0] c_OP_LB  = 6'h20;
  localparam logic [5:0] c_OP_LBU = 6'h24;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alurs_q, alurs_d;
  logic [31:0] wd_q, wd_d;
  logic        rfwr_q, rfwr_d;
  logic [4:0]  dst_q, dst_d;

  logic [31:0] mem_q [DM_WORDS];

  logic [5:0]       w_op;
  logic             w_sw, w_sh, w_sb, w_lw, w_lh, w_lhu, w_lb, w_lbu;
  logic             w_store, w_load, w_word, w_half;
  logic             w_in_range, w_misalign, w_fault;
  logic [DM_AW-1:0] w_idx;
  logic [31:0]      w_sd, w_wdata, w_rword, w_rd;
  logic [3:0]       w_be;
  logic             w_we;
  logic [15:0]      w_rhalf;
  logic [7:0]       w_rbyte;

  // Next-state for the E/M register: a stall turns the slot into a bubble.
  always_comb begin
    instr_d = Instr_E_I;
    pc_d    = PC_E_I;
    alurs_d = ALURS_E_I;
    wd_d    = WD_E_I;
    rfwr_d  = RFWr_E_I;
    dst_d   = DstE_E_I;
    if (Stall_E_I) begin
      instr_d = '0;
      pc_d    = '0;
      alurs_d = '0;
      wd_d    = '0;
      rfwr_d  = 1'b0;
      dst_d   = '0;
    end
  end

  // E/M pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      alurs_q <= '0;
      wd_q    <= '0;
      rfwr_q  <= 1'b0;
      dst_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      alurs_q <= alurs_d;
      wd_q    <= wd_d;
      rfwr_q  <= rfwr_d;
      dst_q   <= dst_d;
    end
  end

  // Decode, fault detection, store-lane steering and load extraction.
  always_comb begin
    w_op  = instr_q[31:26];
    w_sw  = (w_op == c_OP_SW);
    w_sh  = (w_op == c_OP_SH);
    w_sb  = (w_op == c_OP_SB);
    w_lw  = (w_op == c_OP_LW);
    w_lh  = (w_op == c_OP_LH);
    w_lhu = (w_op == c_OP_LHU);
    w_lb  = (w_op == c_OP_LB);
    w_lbu = (w_op == c_OP_LBU);

    w_store = w_sw | w_sh | w_sb;
    w_load  = w_lw | w_lh | w_lhu | w_lb | w_lbu;
    w_word  = w_sw | w_lw;
    w_half  = w_sh | w_lh | w_lhu;

    w_idx      = alurs_q[DM_AW+1:2];
    w_in_range = (alurs_q < c_DM_BYTES);
    w_misalign = (w_word && (alurs_q[1:0] != 2'b00)) || (w_half && alurs_q[0]);
    w_fault    = w_misalign || !w_in_range;

    // Late forwarding from W covers a store whose rt was produced just ahead.
    w_sd = ForwardRtM_M_I ? TWF_M_I : wd_q;

    w_wdata = w_sd;
    w_be    = 4'b1111;
    if (w_sh) begin
      w_wdata = {w_sd[15:0], w_sd[15:0]};
      w_be    = alurs_q[1] ? 4'b1100 : 4'b0011;
    end else if (w_sb) begin
      w_wdata = {4{w_sd[7:0]}};
      w_be    = 4'b0001 << alurs_q[1:0];
    end
    w_we = w_store && !w_fault;

    // Read sees the pre-edge contents, giving read-before-write on a same-edge store.
    w_rword = mem_q[w_idx];
    w_rhalf = alurs_q[1] ? w_rword[31:16] : w_rword[15:0];
    w_rbyte = w_rword[8*alurs_q[1:0] +: 8];

    w_rd = '0;
    if (w_load && !w_fault) begin
      if (w_lw)       w_rd = w_rword;
      else if (w_lh)  w_rd = {{16{w_rhalf[15]}}, w_rhalf};
      else if (w_lhu) w_rd = {16'h0000, w_rhalf};
      else if (w_lb)  w_rd = {{24{w_rbyte[7]}}, w_rbyte};
      else            w_rd = {24'h000000, w_rbyte};
    end
  end

  // Data memory: cleared by reset, byte-enabled write from the instruction in M.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          mem_q[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
        end
      end
    end
  end

  assign Instr_M_O = instr_q;
  assign PC_M_O    = pc_q;
  assign ALURS_M_O = alurs_q;
  assign RD_M_O    = w_rd;
  assign RFWr_M_O  = rfwr_q;
  assign DstM_M_O  = dst_q;
  assign AdEL_M_O  = w_load && w_fault;
  assign AdES_M_O  = w_store && w_fault;

endmodule
`default_nettype wire

// File: tb/tb_m_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_stage
// Brief    : Directed self-checking bench for the memory stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_E_I, PC_E_I, ALURS_E_I, WD_E_I, TWF_M_I;
  logic        RFWr_E_I, Stall_E_I, ForwardRtM_M_I;
  logic [4:0]  DstE_E_I;
  logic [31:0] Instr_M_O, PC_M_O, ALURS_M_O, RD_M_O;
  logic        RFWr_M_O, AdEL_M_O, AdES_M_O;
  logic [4:0]  DstM_M_O;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [5:0] SW = 6'h2B, SH = 6'h29, SB = 6'h28, LW = 6'h23,
                         LH = 6'h21, LHU = 6'h25, LB = 6'h20, LBU = 6'h24;

  m_stage dut (
    .clk(clk), .reset(reset),
    .Instr_E_I(Instr_E_I), .PC_E_I(PC_E_I), .ALURS_E_I(ALURS_E_I),
    .WD_E_I(WD_E_I), .RFWr_E_I(RFWr_E_I), .DstE_E_I(DstE_E_I),
    .Stall_E_I(Stall_E_I), .ForwardRtM_M_I(ForwardRtM_M_I), .TWF_M_I(TWF_M_I),
    .Instr_M_O(Instr_M_O), .PC_M_O(PC_M_O), .ALURS_M_O(ALURS_M_O),
    .RD_M_O(RD_M_O), .RFWr_M_O(RFWr_M_O), .DstM_M_O(DstM_M_O),
    .AdEL_M_O(AdEL_M_O), .AdES_M_O(AdES_M_O)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction at E, capture it on the next edge, settle 1 time unit.
  task automatic step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input logic rfwr, input logic [4:0] dst, input logic stall);
    Instr_E_I = {op, 5'd1, 5'd2, 16'h0000};
    PC_E_I    = 32'h0000_3000 + a;
    ALURS_E_I = a;
    WD_E_I    = wd;
    RFWr_E_I  = rfwr;
    DstE_E_I  = dst;
    Stall_E_I = stall;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    Instr_E_I = '0; PC_E_I = '0; ALURS_E_I = '0; WD_E_I = '0;
    RFWr_E_I = 1'b0; DstE_E_I = '0; Stall_E_I = 1'b0;
    ForwardRtM_M_I = 1'b0; TWF_M_I = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", Instr_M_O, 32'h0);
    chk("rst_pc",    PC_M_O, 32'h0);
    chk("rst_alurs", ALURS_M_O, 32'h0);
    chk("rst_rd",    RD_M_O, 32'h0);
    chk("rst_flags", {29'h0, RFWr_M_O, AdEL_M_O, AdES_M_O}, 32'h0);
    chk("rst_dst",   {27'h0, DstM_M_O}, 32'h0);
    reset = 1'b1;

    step(LW, 32'h0, 32'h0, 1'b1, 5'd4, 1'b0);
    chk("lw0_rd", RD_M_O, 32'h0);
    chk("lw0_adel", {31'h0, AdEL_M_O}, 32'h0);

    // Word store, load back, byte merge
    step(SW, 32'h10, 32'hAABBCCDD, 1'b0, 5'd0, 1'b0);
    chk("sw_instr", Instr_M_O, {SW, 5'd1, 5'd2, 16'h0});
    chk("sw_pc", PC_M_O, 32'h3010);
    chk("sw_ades", {31'h0, AdES_M_O}, 32'h0);
    step(LW, 32'h10, 32'h0, 1'b1, 5'd5, 1'b0);
    chk("lw10_rd", RD_M_O, 32'hAABBCCDD);
    chk("lw10_rfwr", {31'h0, RFWr_M_O}, 32'h1);
    chk("lw10_dst", {27'h0, DstM_M_O}, 32'd5);
    chk("lw10_alurs", ALURS_M_O, 32'h10);
    step(SB, 32'h12, 32'h00000011, 1'b0, 5'd0, 1'b0);
    chk("sb_rd_zero", RD_M_O, 32'h0);
    step(LW, 32'h10, 32'h0, 1'b1, 5'd5, 1'b0);
    chk("lw10_merged", RD_M_O, 32'hAA11CCDD);

    // Load extension
    step(SW, 32'h20, 32'h000080F0, 1'b0, 5'd0, 1'b0);
    step(LB, 32'h20, 32'h0, 1'b1, 5'd6, 1'b0);
    chk("lb20", RD_M_O, 32'hFFFFFFF0);
    step(LBU, 32'h20, 32'h0, 1'b1, 5'd6, 1'b0);
    chk("lbu20", RD_M_O, 32'h000000F0);
    step(LH, 32'h20, 32'h0, 1'b1, 5'd6, 1'b0);
    chk("lh20", RD_M_O, 32'hFFFF80F0);
    step(LHU, 32'h20, 32'h0, 1'b1, 5'd6, 1'b0);
    chk("lhu20", RD_M_O, 32'h000080F0);
    step(LH, 32'h22, 32'h0, 1'b1, 5'd6, 1'b0);
    chk("lh22", RD_M_O, 32'h00000000);
    step(LB, 32'h21, 32'h0, 1'b1, 5'd6, 1'b0);
    chk("lb21", RD_M_O, 32'hFFFFFF80);

    // Stall inserts a bubble; the stalled store never writes
    step(SW, 32'h20, 32'hDEADBEEF, 1'b1, 5'd3, 1'b1);
    chk("stall_instr", Instr_M_O, 32'h0);
    chk("stall_pc", PC_M_O, 32'h0);
    chk("stall_rfwr", {31'h0, RFWr_M_O}, 32'h0);
    chk("stall_dst", {27'h0, DstM_M_O}, 32'h0);
    step(NOP_OP(), 32'h20, 32'h0, 1'b0, 5'd0, 1'b0);
    step(LW, 32'h20, 32'h0, 1'b1, 5'd7, 1'b0);
    chk("stall_mem", RD_M_O, 32'h000080F0);

    // Faults and halfword store
    step(SW, 32'h30, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0);
    step(SH, 32'h31, 32'h00001234, 1'b0, 5'd0, 1'b0);
    chk("sh31_ades", {31'h0, AdES_M_O}, 32'h1);
    step(LW, 32'h30, 32'h0, 1'b1, 5'd8, 1'b0);
    chk("sh31_nowrite", RD_M_O, 32'hCAFEF00D);
    step(SH, 32'h32, 32'h0000BEEF, 1'b0, 5'd0, 1'b0);
    chk("sh32_ades", {31'h0, AdES_M_O}, 32'h0);
    step(LW, 32'h30, 32'h0, 1'b1, 5'd8, 1'b0);
    chk("sh32_merged", RD_M_O, 32'hBEEFF00D);
    step(SW, 32'h1000, 32'h55555555, 1'b0, 5'd0, 1'b0);
    chk("sw1000_ades", {31'h0, AdES_M_O}, 32'h1);
    step(LW, 32'h0, 32'h0, 1'b1, 5'd8, 1'b0);
    chk("sw1000_nowrite", RD_M_O, 32'h0);
    step(LW, 32'h6, 32'h0, 1'b1, 5'd8, 1'b0);
    chk("lw6_adel", {31'h0, AdEL_M_O}, 32'h1);
    chk("lw6_rd", RD_M_O, 32'h0);
    step(LHU, 32'h33, 32'h0, 1'b1, 5'd8, 1'b0);
    chk("lhu33_adel", {31'h0, AdEL_M_O}, 32'h1);

    // Store-data forwarding from W
    step(SW, 32'h40, 32'h0, 1'b0, 5'd0, 1'b0);
    ForwardRtM_M_I = 1'b1;
    TWF_M_I = 32'h12345678;
    step(LW, 32'h40, 32'h0, 1'b1, 5'd9, 1'b0);
    ForwardRtM_M_I = 1'b0;
    TWF_M_I = 32'h0;
    chk("fwd_sw", RD_M_O, 32'h12345678);

    // Reset during a store aborts it and clears memory
    step(SW, 32'h50, 32'h77777777, 1'b0, 5'd0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_instr", Instr_M_O, 32'h0);
    reset = 1'b1;
    step(LW, 32'h50, 32'h0, 1'b1, 5'd9, 1'b0);
    chk("rst_mid_word", RD_M_O, 32'h0);
    step(LW, 32'h10, 32'h0, 1'b1, 5'd9, 1'b0);
    chk("rst_mem_clear", RD_M_O, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic logic [5:0] NOP_OP();
    return 6'h00;
  endfunction

endmodule
`default_nettype wire
